// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - fetch, load/store and byte-RAM signal bundle for mem_ctrl
interface mem_ctrl_if;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] inst_out;
    logic        read_req_in;
    logic        write_req_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_val_in;
    logic [2:0]  store_len_in;
    logic        mem_done_out;
    logic [31:0] mem_val_read_out;
    logic [1:0]  busy_out;
    logic [7:0]  ram_din_in;
    logic [7:0]  ram_dout_out;
    logic [31:0] ram_addr_out;
    logic        ram_wr_out;

    modport slave (
        input  if_req_in, if_addr_in, read_req_in, write_req_in,
               mem_addr_in, mem_val_in, store_len_in, ram_din_in,
        output if_done_out, inst_out, mem_done_out, mem_val_read_out,
               busy_out, ram_dout_out, ram_addr_out, ram_wr_out
    );

    modport master (
        output if_req_in, if_addr_in, read_req_in, write_req_in,
               mem_addr_in, mem_val_in, store_len_in, ram_din_in,
        input  if_done_out, inst_out, mem_done_out, mem_val_read_out,
               busy_out, ram_dout_out, ram_addr_out, ram_wr_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller for fetch and load/store; optional IO_ADDR_GUARD_EN
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    mem_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;        // edges elapsed since acceptance
    logic [2:0]  nlast_q, nlast_d;    // index of last byte (N-1)
    logic [31:0] ram_addr_q, ram_addr_d;
    logic        ram_wr_q, ram_wr_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic [23:0] wdata_q, wdata_d;    // store bytes not yet driven
    logic [31:0] rdata_q, rdata_d;    // read bytes gathered so far
    logic [31:0] inst_q, inst_d;
    logic [31:0] mem_val_q, mem_val_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [2:0]  read_nlast;
    logic [1:0]  rd_idx;

    // Load length: the IO window returns a single byte when guarding is built in
    always_comb begin
        read_nlast = 3'd3;
`ifdef IO_ADDR_GUARD_EN
        if (bus.mem_addr_in[17:16] == 2'b11) begin
            read_nlast = 3'd0;
        end
`endif
    end

    // Next-state, byte sequencing and result assembly
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nlast_d    = nlast_q;
        ram_addr_d = ram_addr_q;
        ram_wr_d   = ram_wr_q;
        ram_dout_d = ram_dout_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        inst_d     = inst_q;
        mem_val_d  = mem_val_q;
        if_done_d  = 1'b0;
        mem_done_d = 1'b0;
        // the byte arriving now was addressed two edges ago
        rd_idx     = cnt_q[1:0] - 2'd1;

        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (bus.write_req_in) begin
                    state_d    = MEM_WR;
                    ram_addr_d = bus.mem_addr_in;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = bus.mem_val_in[7:0];
                    wdata_d    = bus.mem_val_in[31:8];
                    case (bus.store_len_in)
                        3'b000:  nlast_d = 3'd0;
                        3'b001:  nlast_d = 3'd1;
                        default: nlast_d = 3'd3;
                    endcase
                end else if (bus.read_req_in) begin
                    state_d    = MEM_RD;
                    ram_addr_d = bus.mem_addr_in;
                    ram_wr_d   = 1'b0;
                    nlast_d    = read_nlast;
                    rdata_d    = 32'd0;
                end else if (bus.if_req_in) begin
                    state_d    = IF_RD;
                    ram_addr_d = bus.if_addr_in;
                    ram_wr_d   = 1'b0;
                    nlast_d    = 3'd3;
                    rdata_d    = 32'd0;
                end
            end

            IF_RD, MEM_RD: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) begin
                    rdata_d[{rd_idx, 3'b000} +: 8] = bus.ram_din_in;
                end
                if (cnt_q < nlast_q) begin
                    ram_addr_d = ram_addr_q + 32'd1;
                end
                if (cnt_q == nlast_q + 3'd1) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == IF_RD) begin
                        inst_d    = rdata_d;
                        if_done_d = 1'b1;
                    end else begin
                        mem_val_d  = rdata_d;
                        mem_done_d = 1'b1;
                    end
                end
            end

            MEM_WR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == nlast_q) begin
                    state_d    = IDLE;
                    cnt_d      = 3'd0;
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
                end else begin
                    ram_addr_d = ram_addr_q + 32'd1;
                    ram_dout_d = wdata_q[7:0];
                    wdata_d    = {8'h00, wdata_q[23:8]};
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = 3'd0;
                ram_wr_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction at once
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            nlast_q    <= 3'd0;
            ram_addr_q <= 32'd0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'd0;
            wdata_q    <= 24'd0;
            rdata_q    <= 32'd0;
            inst_q     <= 32'd0;
            mem_val_q  <= 32'd0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nlast_q    <= nlast_d;
            ram_addr_q <= ram_addr_d;
            ram_wr_q   <= ram_wr_d;
            ram_dout_q <= ram_dout_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            inst_q     <= inst_d;
            mem_val_q  <= mem_val_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    // Busy code reflects which stage owns the RAM
    always_comb begin
        case (state_q)
            IF_RD:          bus.busy_out = 2'b01;
            MEM_RD, MEM_WR: bus.busy_out = 2'b10;
            default:        bus.busy_out = 2'b00;
        endcase
    end

    assign bus.if_done_out      = if_done_q;
    assign bus.inst_out         = inst_q;
    assign bus.mem_done_out     = mem_done_q;
    assign bus.mem_val_read_out = mem_val_q;
    assign bus.ram_dout_out     = ram_dout_q;
    assign bus.ram_addr_out     = ram_addr_q;
    assign bus.ram_wr_out       = ram_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
    logic clk_in;
    logic rst_in;
    int   checks;
    int   failures;
    logic [7:0] mem [0:4095];
    logic any_done;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Byte RAM: read data one cycle after its address, write on the edge
    always @(posedge clk_in) begin
        bus.ram_din_in <= mem[bus.ram_addr_out[11:0]];
        if (bus.ram_wr_out) begin
            mem[bus.ram_addr_out[11:0]] <= bus.ram_dout_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h13; mem[12'h101] = 8'h05;
        mem[12'h300] = 8'h11; mem[12'h301] = 8'h22; mem[12'h302] = 8'h33; mem[12'h303] = 8'h44;
        mem[12'h000] = 8'h41; mem[12'h001] = 8'h99; mem[12'h002] = 8'h88; mem[12'h003] = 8'h77;

        bus.if_req_in    = 1'b0;
        bus.if_addr_in   = 32'd0;
        bus.read_req_in  = 1'b0;
        bus.write_req_in = 1'b0;
        bus.mem_addr_in  = 32'd0;
        bus.mem_val_in   = 32'd0;
        bus.store_len_in = 3'b000;
        bus.ram_din_in   = 8'd0;
        rst_in = 1'b1;
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);

        chk("rst_busy", {30'd0, bus.busy_out}, 32'd0);
        chk("rst_flags", {28'd0, bus.if_done_out, bus.mem_done_out, bus.ram_wr_out, 1'b0}, 32'd0);
        chk("rst_addr", bus.ram_addr_out, 32'd0);
        chk("rst_inst", bus.inst_out, 32'd0);
        rst_in = 1'b1;
        step();

        // Fetch 0x100 -> 0x00000513, done after E5
        bus.if_req_in  = 1'b1;
        bus.if_addr_in = 32'h100;
        step();                                             // E0
        chk("fetch_busy_e0", {30'd0, bus.busy_out}, 32'd1);
        chk("fetch_addr_e0", bus.ram_addr_out, 32'h100);
        bus.if_addr_in = 32'h7777;                          // must be ignored
        step(); step(); step();                             // E3
        chk("fetch_addr_e3", bus.ram_addr_out, 32'h103);
        step();                                             // E4
        chk("fetch_busy_e4", {30'd0, bus.busy_out}, 32'd1);
        chk("fetch_nodone_e4", {31'd0, bus.if_done_out}, 32'd0);
        step();                                             // E5
        chk("fetch_done_e5", {31'd0, bus.if_done_out}, 32'd1);
        chk("fetch_inst", bus.inst_out, 32'h00000513);
        chk("fetch_busy_done", {30'd0, bus.busy_out}, 32'd0);
        bus.if_req_in = 1'b0;
        step();
        chk("fetch_pulse_1cyc", {31'd0, bus.if_done_out}, 32'd0);
        chk("fetch_inst_hold", bus.inst_out, 32'h00000513);

        // Store 0xDEADBEEF len 011 at 0x200
        bus.write_req_in = 1'b1;
        bus.mem_addr_in  = 32'h200;
        bus.mem_val_in   = 32'hDEADBEEF;
        bus.store_len_in = 3'b011;
        step();                                             // E0
        chk("st_wr_e0", {31'd0, bus.ram_wr_out}, 32'd1);
        chk("st_dout_e0", {24'd0, bus.ram_dout_out}, 32'hEF);
        chk("st_busy_e0", {30'd0, bus.busy_out}, 32'd2);
        bus.mem_val_in  = 32'h12345678;                     // must be ignored
        bus.mem_addr_in = 32'h555;
        step(); step(); step();                             // E3
        chk("st_addr_e3", bus.ram_addr_out, 32'h203);
        chk("st_dout_e3", {24'd0, bus.ram_dout_out}, 32'hDE);
        chk("st_nodone_e3", {31'd0, bus.mem_done_out}, 32'd0);
        step();                                             // E4
        chk("st_done_e4", {31'd0, bus.mem_done_out}, 32'd1);
        chk("st_wr_e4", {31'd0, bus.ram_wr_out}, 32'd0);
        bus.write_req_in = 1'b0;
        step();
        chk("st_mem", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}, 32'hDEADBEEF);

        // Simultaneous fetch and load: load first, fetch right after
        bus.if_req_in   = 1'b1;
        bus.if_addr_in  = 32'h100;
        bus.read_req_in = 1'b1;
        bus.mem_addr_in = 32'h300;
        step();                                             // E0
        chk("pri_busy_e0", {30'd0, bus.busy_out}, 32'd2);
        chk("pri_addr_e0", bus.ram_addr_out, 32'h300);
        step(); step(); step(); step(); step();             // E5
        chk("pri_ld_done", {31'd0, bus.mem_done_out}, 32'd1);
        chk("pri_ld_val", bus.mem_val_read_out, 32'h44332211);
        bus.read_req_in = 1'b0;
        step();
        chk("pri_if_busy", {30'd0, bus.busy_out}, 32'd1);
        chk("pri_if_addr", bus.ram_addr_out, 32'h100);
        chk("pri_ld_hold", bus.mem_val_read_out, 32'h44332211);

        // Store raised during the fetch is served before any further fetch
        step();                                             // fetch E1
        bus.write_req_in = 1'b1;
        bus.mem_addr_in  = 32'h250;
        bus.mem_val_in   = 32'h0000005A;
        bus.store_len_in = 3'b000;
        step(); step(); step(); step();                     // fetch E5
        chk("mid_if_done", {31'd0, bus.if_done_out}, 32'd1);
        step();                                             // store E0 (fetch req still high)
        chk("mid_st_busy", {30'd0, bus.busy_out}, 32'd2);
        chk("mid_st_addr", bus.ram_addr_out, 32'h250);
        bus.if_req_in = 1'b0;
        step();                                             // store E1
        chk("mid_st_done", {31'd0, bus.mem_done_out}, 32'd1);
        bus.write_req_in = 1'b0;
        step();
        chk("mid_st_mem", {24'd0, mem[12'h250]}, 32'h5A);

        // Reset just after E2 of a 4-byte store
        bus.write_req_in = 1'b1;
        bus.mem_addr_in  = 32'h400;
        bus.mem_val_in   = 32'h04030201;
        bus.store_len_in = 3'b011;
        @(posedge clk_in);                                  // E0
        @(posedge clk_in);                                  // E1
        @(posedge clk_in);                                  // E2
        #1 rst_in = 1'b0;
        bus.write_req_in = 1'b0;
        #1;
        chk("rstm_wr", {31'd0, bus.ram_wr_out}, 32'd0);
        chk("rstm_addr", bus.ram_addr_out, 32'd0);
        chk("rstm_busy", {30'd0, bus.busy_out}, 32'd0);
        chk("rstm_ld_val", bus.mem_val_read_out, 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            any_done = any_done | bus.mem_done_out | bus.if_done_out;
        end
        chk("rstm_nodone", {31'd0, any_done}, 32'd0);
        chk("rstm_mem", {mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]}, 32'h00000201);
        rst_in = 1'b1;
        step();

        // Load from the IO window 0x30000
        bus.read_req_in = 1'b1;
        bus.mem_addr_in = 32'h30000;
        step();                                             // E0
        step();                                             // E1
        chk("io_nodone_e1", {31'd0, bus.mem_done_out}, 32'd0);
        step();                                             // E2
`ifdef IO_ADDR_GUARD_EN
        chk("io_done_e2", {31'd0, bus.mem_done_out}, 32'd1);
        chk("io_val", bus.mem_val_read_out, 32'h00000041);
`else
        chk("io_nodone_e2", {31'd0, bus.mem_done_out}, 32'd0);
        step(); step(); step();                             // E5
        chk("io_done_e5", {31'd0, bus.mem_done_out}, 32'd1);
        chk("io_val", bus.mem_val_read_out, 32'h77889941);
`endif
        bus.read_req_in = 1'b0;
        step();
        chk("io_idle", {30'd0, bus.busy_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
